// File: rtl/uart_apb_pkg.sv
// Shared definitions for the UART APB register map, the status/control
// bit layout and the state encodings of the initiator.
package uart_apb_pkg;

    // Register byte offsets
    localparam logic [4:0] ADDR_TXDATA = 5'h00;
    localparam logic [4:0] ADDR_RXDATA = 5'h04;
    localparam logic [4:0] ADDR_CTRL1  = 5'h08;
    localparam logic [4:0] ADDR_CTRL2  = 5'h0C;
    localparam logic [4:0] ADDR_STATUS = 5'h10;

    // STATUS bit indices
    localparam int ST_TXRDY    = 0;
    localparam int ST_RXRDY    = 1;
    localparam int ST_PARITY   = 2;
    localparam int ST_OVERFLOW = 3;
    localparam int ST_FRAMING  = 4;

    // CTRL2 field positions
    localparam int CTRL2_BIT8       = 0;
    localparam int CTRL2_PARITY_EN  = 1;
    localparam int CTRL2_ODD_N_EVEN = 2;
    localparam int CTRL2_BAUD_LSB   = 3;

    // Initiator sequencer states
    typedef enum logic [2:0] {
        SEQ_CFG1,
        SEQ_CFG2,
        SEQ_POLL,
        SEQ_RXRD,
        SEQ_TXWR,
        SEQ_GAP
    } seq_state_e;

    // APB engine states
    typedef enum logic [1:0] {
        APB_IDLE,
        APB_SETUP,
        APB_ACCESS
    } apb_state_e;

    // Builds the CTRL2 byte from the upper baud bits and framing options.
    function automatic logic [7:0] ctrl2_pack(input logic [4:0] baud_hi,
                                              input logic       odd_n_even,
                                              input logic       parity_en,
                                              input logic       bit8);
        logic [7:0] v;
        v = '0;
        v[CTRL2_BAUD_LSB +: 5] = baud_hi;
        v[CTRL2_ODD_N_EVEN]    = odd_n_even;
        v[CTRL2_PARITY_EN]     = parity_en;
        v[CTRL2_BIT8]          = bit8;
        return v;
    endfunction

endpackage

// File: rtl/apb_single_master.sv
// Generic APB3 engine running one transfer at a time. A request is taken
// when idle, or in the completion cycle of the current transfer so a queued
// transfer goes straight to SETUP. Address/direction/data are latched on
// acceptance and held until the transfer completes.
module apb_single_master
    import uart_apb_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       start_i,
    input  logic [4:0] addr_i,
    input  logic       write_i,
    input  logic [7:0] wdata_i,
    output logic       busy_o,
    output logic       done_o,
    output logic [7:0] rdata_o,
    output logic       slverr_o,
    output logic [4:0] paddr_o,
    output logic       psel_o,
    output logic       penable_o,
    output logic       pwrite_o,
    output logic [7:0] pwdata_o,
    input  logic [7:0] prdata_i,
    input  logic       pready_i,
    input  logic       pslverr_i
);

    apb_state_e state_q, state_d;
    logic [4:0] addr_q;
    logic       write_q;
    logic [7:0] wdata_q;
    logic       accept;

    // Next-state: IDLE -> SETUP -> ACCESS, ACCESS held until the slave is ready
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        case (state_q)
            APB_IDLE: begin
                if (start_i) begin
                    state_d = APB_SETUP;
                    accept  = 1'b1;
                end
            end
            APB_SETUP: begin
                state_d = APB_ACCESS;
            end
            APB_ACCESS: begin
                if (pready_i) begin
                    if (start_i) begin
                        state_d = APB_SETUP;
                        accept  = 1'b1;
                    end else begin
                        state_d = APB_IDLE;
                    end
                end
            end
            default: state_d = APB_IDLE;
        endcase
    end

    // State register and request latch; reset abandons any transfer at once
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= APB_IDLE;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                addr_q  <= addr_i;
                write_q <= write_i;
                wdata_q <= wdata_i;
            end
        end
    end

    assign psel_o    = (state_q != APB_IDLE);
    assign penable_o = (state_q == APB_ACCESS);
    assign paddr_o   = addr_q;
    assign pwrite_o  = write_q;
    assign pwdata_o  = wdata_q;
    assign busy_o    = (state_q != APB_IDLE);
    assign done_o    = (state_q == APB_ACCESS) && pready_i;
    assign rdata_o   = prdata_i;
    assign slverr_o  = pslverr_i;

endmodule

// File: rtl/uart_apb_initiator.sv
// Drives a single UART APB slave without a CPU: writes the two control
// registers once, then loops reading STATUS and either fetching a received
// byte, pushing a transmit byte, or idling for a configurable gap.
module uart_apb_initiator
    import uart_apb_pkg::*;
#(
    parameter logic [12:0] BAUD_VALUE = 13'd1,
    parameter bit          BIT8       = 1'b1,
    parameter bit          PARITY_EN  = 1'b0,
    parameter bit          ODD_N_EVEN = 1'b0,
    parameter int unsigned POLL_GAP   = 0
) (
    input  logic       PCLK,
    input  logic       PRESETN,
    output logic [4:0] PADDR,
    output logic       PSEL,
    output logic       PENABLE,
    output logic       PWRITE,
    output logic [7:0] PWDATA,
    input  logic [7:0] PRDATA,
    input  logic       PREADY,
    input  logic       PSLVERR,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       cfg_done,
    output logic       err_parity,
    output logic       err_overflow,
    output logic       err_framing,
    output logic       err_apb,
    input  logic       err_clr
);

    localparam logic [7:0] CTRL1_VAL = BAUD_VALUE[7:0];
    localparam logic [7:0] CTRL2_VAL = ctrl2_pack(BAUD_VALUE[12:8], ODD_N_EVEN, PARITY_EN, BIT8);
    // Loaded on entry to GAP so that exactly POLL_GAP cycles are spent there
    localparam logic [7:0] GAP_LOAD  = 8'(POLL_GAP - 1);

    seq_state_e seq_q, seq_d;
    logic [7:0] gap_q, gap_d;
    logic [7:0] rx_data_q, rx_data_d;
    logic       rx_valid_q, rx_valid_d;
    logic       cfg_done_q, cfg_done_d;
    logic [3:0] err_q, err_d;   // {apb, framing, overflow, parity}

    logic       start;
    logic [4:0] req_addr;
    logic       req_write;
    logic [7:0] req_wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic       slverr;

    apb_single_master u_apb (
        .clk_i     (PCLK),
        .rst_ni    (PRESETN),
        .start_i   (start),
        .addr_i    (req_addr),
        .write_i   (req_write),
        .wdata_i   (req_wdata),
        .busy_o    (busy),
        .done_o    (done),
        .rdata_o   (rdata),
        .slverr_o  (slverr),
        .paddr_o   (PADDR),
        .psel_o    (PSEL),
        .penable_o (PENABLE),
        .pwrite_o  (PWRITE),
        .pwdata_o  (PWDATA),
        .prdata_i  (PRDATA),
        .pready_i  (PREADY),
        .pslverr_i (PSLVERR)
    );

    // Sequencer: issue one transfer per state when the engine is free and
    // choose the follow-up on its completion cycle
    always_comb begin
        seq_d      = seq_q;
        gap_d      = gap_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q;
        cfg_done_d = cfg_done_q;
        start      = 1'b0;
        req_addr   = ADDR_STATUS;
        req_write  = 1'b0;
        req_wdata  = '0;

        if (rx_valid_q && rx_ready) begin
            rx_valid_d = 1'b0;
        end

        case (seq_q)
            SEQ_CFG1: begin
                req_addr  = ADDR_CTRL1;
                req_write = 1'b1;
                req_wdata = CTRL1_VAL;
                start     = !busy;
                if (done) seq_d = SEQ_CFG2;
            end
            SEQ_CFG2: begin
                req_addr  = ADDR_CTRL2;
                req_write = 1'b1;
                req_wdata = CTRL2_VAL;
                start     = !busy;
                if (done) begin
                    seq_d      = SEQ_POLL;
                    cfg_done_d = 1'b1;
                end
            end
            SEQ_POLL: begin
                req_addr = ADDR_STATUS;
                start    = !busy;
                if (done) begin
                    // RX first; a held rx byte blocks further RXDATA reads
                    if (rdata[ST_RXRDY] && !rx_valid_q) begin
                        seq_d = SEQ_RXRD;
                    end else if (rdata[ST_TXRDY] && tx_valid) begin
                        seq_d = SEQ_TXWR;
                    end else if (POLL_GAP != 0) begin
                        seq_d = SEQ_GAP;
                        gap_d = GAP_LOAD;
                    end else begin
                        seq_d = SEQ_POLL;
                    end
                end
            end
            SEQ_RXRD: begin
                req_addr = ADDR_RXDATA;
                start    = !busy;
                if (done) begin
                    rx_data_d  = rdata;
                    rx_valid_d = 1'b1;
                    seq_d      = SEQ_POLL;
                end
            end
            SEQ_TXWR: begin
                req_addr  = ADDR_TXDATA;
                req_write = 1'b1;
                req_wdata = tx_data;
                // The producer may withdraw before SETUP; then no write happens
                if (!busy) begin
                    if (tx_valid) start = 1'b1;
                    else          seq_d = SEQ_POLL;
                end
                if (done) seq_d = SEQ_POLL;
            end
            SEQ_GAP: begin
                if (gap_q == 8'd0) seq_d = SEQ_POLL;
                else               gap_d = gap_q - 8'd1;
            end
            default: seq_d = SEQ_CFG1;
        endcase
    end

    // Sticky error flags; a set in the same cycle as err_clr takes priority
    always_comb begin
        err_d = err_q;
        if (err_clr) begin
            err_d = '0;
        end
        if (done && (seq_q == SEQ_POLL)) begin
            if (rdata[ST_PARITY])   err_d[0] = 1'b1;
            if (rdata[ST_OVERFLOW]) err_d[1] = 1'b1;
            if (rdata[ST_FRAMING])  err_d[2] = 1'b1;
        end
        if (done && slverr) begin
            err_d[3] = 1'b1;
        end
    end

    // State and holding registers
    always_ff @(posedge PCLK) begin
        if (!PRESETN) begin
            seq_q      <= SEQ_CFG1;
            gap_q      <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            cfg_done_q <= 1'b0;
            err_q      <= '0;
        end else begin
            seq_q      <= seq_d;
            gap_q      <= gap_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            cfg_done_q <= cfg_done_d;
            err_q      <= err_d;
        end
    end

    assign tx_ready     = done && (seq_q == SEQ_TXWR);
    assign rx_data      = rx_data_q;
    assign rx_valid     = rx_valid_q;
    assign cfg_done     = cfg_done_q;
    assign err_parity   = err_q[0];
    assign err_overflow = err_q[1];
    assign err_framing  = err_q[2];
    assign err_apb      = err_q[3];

endmodule
